strobe_gen: RTL

Programmable strobe generator driving the enable input of a downstream wrap-around counter. After a start request it emits one-cycle pulses on `stb_o` every `period_i` clock cycles. The strobes run either continuously or for a fixed burst length, and software can abort at any time with `stop_i`. It sits directly upstream of the counter stage, so the counter advances once per strobe.

---
 rtl/strobe_gen_pkg.sv | 6 +
 rtl/strobe_gen_phase.sv | 22 ++
 rtl/strobe_gen.sv | 70 +++++++
 3 files changed

// File: rtl/strobe_gen_pkg.sv
// strobe_gen_pkg: shared state encoding and default widths for strobe_gen
package strobe_gen_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
  localparam int PWIDTH_DEF = 16;
  localparam int BWIDTH_DEF = 8;
endpackage

// File: rtl/strobe_gen_phase.sv
// strobe_gen_phase: period phase counter; clr restarts at phase 0 in the same cycle, wrap flags phase == last
module strobe_gen_phase
  import strobe_gen_pkg::*;
#(
  parameter int PWIDTH = PWIDTH_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr,
  input  logic              en,
  input  logic [PWIDTH-1:0] last,
  output logic              wrap
);
  logic [PWIDTH-1:0] cnt;
  logic [PWIDTH-1:0] cur;
  assign cur  = clr ? '0 : cnt;
  assign wrap = (clr || en) && cur == last;
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt <= '0;
    else if (clr || en) cnt <= wrap ? '0 : cur + 1'b1;
  end
endmodule

// File: rtl/strobe_gen.sv
// strobe_gen: periodic one-cycle strobe generator with optional burst length (burst mode under STROBE_GEN_BURST_EN)
module strobe_gen
  import strobe_gen_pkg::*;
#(
  parameter int PWIDTH = PWIDTH_DEF,
  parameter int BWIDTH = BWIDTH_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [PWIDTH-1:0] period_i,
  input  logic [BWIDTH-1:0] burst_i,
  output logic              stb_o,
  output logic              busy_o,
  output logic              done_o
);
  state_t state, state_nx;
  logic [PWIDTH-1:0] last_r, last;
  logic go, tick, wrap, fin;
  assign go     = state == ST_IDLE && start_i && !stop_i;
  assign tick   = state == ST_RUN && !stop_i && !done_o;
  assign last   = go ? ((period_i == '0) ? '0 : period_i - 1'b1) : last_r;
  assign busy_o = state == ST_RUN;
  strobe_gen_phase #(.PWIDTH(PWIDTH)) u_phase (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr  (go),
    .en   (tick),
    .last (last),
    .wrap (wrap)
  );
`ifdef STROBE_GEN_BURST_EN
  logic [BWIDTH-1:0] b_r, n, b_cur, n_cur;
  assign b_cur = go ? burst_i : b_r;
  assign n_cur = go ? '0 : n;
  assign fin   = wrap && b_cur != '0 && n_cur == b_cur - 1'b1;
  // strobe count saturates so continuous runs never alias a completion
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      b_r <= '0;
      n   <= '0;
    end else if (go || wrap) begin
      b_r <= b_cur;
      n   <= (wrap && !(&n_cur)) ? n_cur + 1'b1 : n_cur;
    end
  end
`else
  logic unused_burst;
  assign unused_burst = ^burst_i;
  assign fin = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    state_nx = go ? ST_RUN : (state == ST_RUN && (stop_i || done_o)) ? ST_IDLE : state;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= ST_IDLE;
      last_r <= '0;
      stb_o  <= 1'b0;
      done_o <= 1'b0;
    end else begin
      state  <= state_nx;
      if (go) last_r <= last;
      stb_o  <= wrap;
      done_o <= fin;
    end
  end
endmodule
